wb_burst_master: RTL and testbench



---
 rtl/wb_master_pkg.sv | 27 ++
 rtl/wb_ack_timer.sv | 30 +++
 rtl/wb_burst_master.sv | 210 +++++++++++++++++++++
 tb/tb_wb_burst_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types, bus constants and the data pattern generator for the
// Wishbone burst traffic master.
package wb_master_pkg;

  typedef enum logic [1:0] {
    MODE_WR   = 2'b00,
    MODE_RD   = 2'b01,
    MODE_WRRD = 2'b10
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WR,
    ST_GAP,
    ST_RD,
    ST_DONE
  } state_e;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB  = 3'b111;

  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [15:0] k);
    return seed ^ {k, ~k};
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Ack watchdog: down-counter reloaded on clear, decremented while enabled,
// expired once it reaches zero (TIMEOUT_CYC-1 enabled cycles after a clear).
module wb_ack_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= LOAD;
    end else if (i_clr) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst initiator: seeded-pattern write, read-check or write-then-read
// bursts with mismatch counting and ack timeout. All outputs are registered.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for cmd_valid
// ST_CHECK | validate latched command, present beat 0 or flag illegal
// ST_WR    | write burst on the bus, one beat per ack
// ST_GAP   | one idle cycle between write and read phases
// ST_RD    | read burst, each acked beat compared with the pattern
// ST_DONE  | done pulse cycle, status holds
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int APP_AW      = 26,
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 1024,
  localparam int LW         = $clog2(MAX_LEN + 1)
) (
  input  logic              sys_clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LW-1:0]     cmd_len,
  input  logic [31:0]       cmd_seed,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [31:0]       wb_dat_i,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              timeout,
  output logic              illegal_cmd
);

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_mode;
  logic [APP_AW-1:0] r_base;
  logic [LW-1:0]     r_len, r_beat;
  logic [31:0]       r_seed;

  logic              w_cyc, w_we, w_done, w_to, w_ill, w_tmr_clr;
  logic [APP_AW-1:0] w_addr, w_ferr, w_next_addr;
  logic [31:0]       w_dat, w_exp_dat;
  logic [2:0]        w_cti, w_first_cti, w_next_cti;
  logic [15:0]       w_err;
  logic [LW-1:0]     w_beat, w_beat_inc;
  logic              w_accept, w_ack, w_last, w_bad_cmd, w_expired;

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_ack       = wb_ack_i && wb_stb_o;
  assign w_last      = (r_beat == r_len - 1'b1);
  assign w_beat_inc  = r_beat + 1'b1;
  assign w_next_addr = r_base + APP_AW'({w_beat_inc, 2'b00});
  assign w_next_cti  = (w_beat_inc == r_len - 1'b1) ? CTI_EOB : CTI_INCR;
  assign w_first_cti = (r_len == LW'(1)) ? CTI_EOB : CTI_INCR;
  assign w_exp_dat   = pattern(r_seed, 16'(r_beat));
  assign w_bad_cmd   = (r_mode == 2'b11) || (r_len == '0) || (r_len > LW'(MAX_LEN));

  wb_ack_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ack_timer (
    .i_clk     (sys_clk),
    .i_rst_n   (resetn),
    .i_clr     (w_tmr_clr),
    .i_en      (wb_stb_o),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cyc       = wb_cyc_o;
    w_we        = wb_we_o;
    w_addr      = wb_addr_o;
    w_dat       = wb_dat_o;
    w_cti       = wb_cti_o;
    w_beat      = r_beat;
    w_done      = 1'b0;
    w_err       = err_cnt;
    w_ferr      = first_err_addr;
    w_to        = timeout;
    w_ill       = illegal_cmd;
    w_tmr_clr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_CHECK;
          w_err       = '0;
          w_ferr      = '0;
          w_to        = 1'b0;
          w_ill       = 1'b0;
        end
      end
      ST_CHECK: begin
        if (w_bad_cmd) begin
          w_ill       = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = (r_mode == MODE_RD) ? ST_RD : ST_WR;
          w_cyc       = 1'b1;
          w_we        = (r_mode == MODE_WR) || (r_mode == MODE_WRRD);
          w_beat      = '0;
          w_addr      = r_base;
          w_dat       = pattern(r_seed, 16'd0);
          w_cti       = w_first_cti;
          w_tmr_clr   = 1'b1;
        end
      end
      ST_WR, ST_RD: begin
        if (w_ack) begin
          w_tmr_clr = 1'b1;
          if ((r_state == ST_RD) && (wb_dat_i != w_exp_dat)) begin
            if (err_cnt == '0) w_ferr = wb_addr_o;
            if (err_cnt != 16'hFFFF) w_err = err_cnt + 16'd1;
          end
          if (w_last) begin
            w_cyc = 1'b0;
            w_we  = 1'b0;
            w_cti = '0;
            if ((r_state == ST_WR) && (r_mode == MODE_WRRD)) begin
              w_state_nxt = ST_GAP;
            end else begin
              w_state_nxt = ST_DONE;
              w_done      = 1'b1;
            end
          end else begin
            w_beat = w_beat_inc;
            w_addr = w_next_addr;
            w_dat  = pattern(r_seed, 16'(w_beat_inc));
            w_cti  = w_next_cti;
          end
        end else if (w_expired) begin
          // Abort skips any remaining beats and the read phase.
          w_cyc       = 1'b0;
          w_we        = 1'b0;
          w_cti       = '0;
          w_to        = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_RD;
        w_cyc       = 1'b1;
        w_we        = 1'b0;
        w_beat      = '0;
        w_addr      = r_base;
        w_dat       = pattern(r_seed, 16'd0);
        w_cti       = w_first_cti;
        w_tmr_clr   = 1'b1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_mode         <= '0;
      r_base         <= '0;
      r_len          <= '0;
      r_seed         <= '0;
      r_beat         <= '0;
      cmd_ready      <= 1'b0;
      wb_cyc_o       <= 1'b0;
      wb_stb_o       <= 1'b0;
      wb_we_o        <= 1'b0;
      wb_addr_o      <= '0;
      wb_dat_o       <= '0;
      wb_sel_o       <= '0;
      wb_cti_o       <= '0;
      done           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      illegal_cmd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mode <= cmd_mode;
        r_base <= cmd_addr & ~APP_AW'(3);
        r_len  <= cmd_len;
        r_seed <= cmd_seed;
      end
      r_beat         <= w_beat;
      cmd_ready      <= (w_state_nxt == ST_IDLE);
      wb_cyc_o       <= w_cyc;
      wb_stb_o       <= w_cyc;
      wb_we_o        <= w_we;
      wb_addr_o      <= w_addr;
      wb_dat_o       <= w_dat;
      wb_sel_o       <= w_cyc ? 4'hF : 4'h0;
      wb_cti_o       <= w_cti;
      done           <= w_done;
      err_cnt        <= w_err;
      first_err_addr <= w_ferr;
      timeout        <= w_to;
      illegal_cmd    <= w_ill;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed-vector bench for wb_burst_master with a small memory-backed
// Wishbone slave (optional ack stall and read-data corruption).
module tb_wb_burst_master;

  localparam int AW = 26;
  localparam int ML = 64;
  localparam int TO = 16;
  localparam int LW = 7;

  logic          sys_clk = 1'b0;
  logic          resetn  = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len  = '0;
  logic [31:0]   cmd_seed = '0;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [31:0]   wb_dat_i;
  logic          done;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;
  logic          timeout, illegal_cmd;

  always #5 sys_clk = ~sys_clk;

  wb_burst_master #(.APP_AW(AW), .MAX_LEN(ML), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .timeout(timeout), .illegal_cmd(illegal_cmd)
  );

  // Slave: combinational ack, word memory indexed by addr[11:2].
  logic [31:0] mem [0:1023];
  logic ack_en = 1'b0;
  logic corrupt_en = 1'b0;
  assign wb_ack_i = wb_stb_o & ack_en;
  assign wb_dat_i = mem[wb_addr_o[11:2]] ^
                    {31'd0, corrupt_en & ((wb_addr_o == 26'h48) | (wb_addr_o == 26'h54))};
  always @(posedge sys_clk)
    if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) mem[wb_addr_o[11:2]] <= wb_dat_o;

  typedef struct {
    logic [1:0]  mode;
    logic [25:0] addr;
    logic [6:0]  len;
    logic [31:0] seed;
    bit          ack;
    bit          corrupt;
    logic [15:0] e_err;
    logic [25:0] e_ferr;
    bit          e_to;
    bit          e_ill;
    int          e_done;
    int          e_stb;
    int          e_gap;
  } vec_t;

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  vec_t vecs[13];
  int n_applied = 0;
  int n_miscmp  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_pat(input logic [31:0] seed, input int k);
    logic [15:0] kk;
    kk = k[15:0];
    return seed ^ {kk, ~kk};
  endfunction

  // Waits for cmd_ready, presents the command, returns at the negedge after accept.
  task automatic issue(input int idx, input logic [1:0] m, input logic [25:0] a,
                       input logic [6:0] l, input logic [31:0] s);
    int waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    chk($sformatf("v%0d cmd_ready before issue", idx), cmd_ready, 1);
    cmd_mode = m; cmd_addr = a; cmd_len = l; cmd_seed = s; cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    beat_t exp_q[$];
    beat_t b;
    int exp_cnt, n_acked = 0, n_stb = 0, n_cyc = 0, n_done = 0;
    int done_cyc = -1, first_stb = -1, last_stb = -1, gap;
    bit legal;
    legal = (v.mode != 2'b11) && (v.len != 0) && (v.len <= ML);
    if (legal && v.ack) begin
      if (v.mode != 2'b01)
        for (int k = 0; k < v.len; k++) begin
          b.we = 1'b1; b.addr = (v.addr & ~26'h3) + 26'(4 * k);
          b.dat = tb_pat(v.seed, k); b.cti = (k == v.len - 1) ? 3'b111 : 3'b010;
          exp_q.push_back(b);
        end
      if (v.mode != 2'b00)
        for (int k = 0; k < v.len; k++) begin
          b.we = 1'b0; b.addr = (v.addr & ~26'h3) + 26'(4 * k);
          b.dat = tb_pat(v.seed, k); b.cti = (k == v.len - 1) ? 3'b111 : 3'b010;
          exp_q.push_back(b);
        end
    end
    exp_cnt = exp_q.size();
    ack_en = v.ack; corrupt_en = v.corrupt;
    issue(idx, v.mode, v.addr, v.len, v.seed);
    for (int c = 1; c <= v.e_done + 2; c++) begin
      if (c > 1) @(negedge sys_clk);
      if (wb_cyc_o) n_cyc++;
      if (wb_stb_o) begin
        n_stb++;
        if (first_stb < 0) first_stb = c;
        last_stb = c;
        chk($sformatf("v%0d sel", idx), wb_sel_o, 4'hF);
        if (wb_ack_i) begin
          n_acked++;
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk($sformatf("v%0d c%0d addr", idx, c), wb_addr_o, b.addr);
            chk($sformatf("v%0d c%0d we", idx, c), wb_we_o, b.we);
            chk($sformatf("v%0d c%0d cti", idx, c), wb_cti_o, b.cti);
            if (b.we) chk($sformatf("v%0d c%0d wdata", idx, c), wb_dat_o, b.dat);
          end
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    gap = (n_stb > 0) ? (last_stb - first_stb + 1 - n_stb) : 0;
    if (n_stb > 0) chk($sformatf("v%0d stb latency", idx), first_stb, 2);
    chk($sformatf("v%0d acked beats", idx), n_acked, exp_cnt);
    chk($sformatf("v%0d stb cycles", idx), n_stb, v.e_stb);
    chk($sformatf("v%0d cyc cycles", idx), n_cyc, v.e_stb);
    chk($sformatf("v%0d gap cycles", idx), gap, v.e_gap);
    chk($sformatf("v%0d done cycle", idx), done_cyc, v.e_done);
    chk($sformatf("v%0d done pulses", idx), n_done, 1);
    chk($sformatf("v%0d err_cnt", idx), err_cnt, v.e_err);
    chk($sformatf("v%0d first_err_addr", idx), first_err_addr, v.e_ferr);
    chk($sformatf("v%0d timeout", idx), timeout, v.e_to);
    chk($sformatf("v%0d illegal_cmd", idx), illegal_cmd, v.e_ill);
    chk($sformatf("v%0d cmd_ready after", idx), cmd_ready, 1);
  endtask

  initial begin
    //          mode   addr          len     seed          ack   cor   err    ferr         to    ill   done stb gap
    vecs[0]  = '{2'd0, 26'h100,     7'd4,  32'hA5A50000, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,   6,  4, 0};
    vecs[1]  = '{2'd2, 26'h2000,    7'd8,  32'h12345678, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,  19, 16, 1};
    vecs[2]  = '{2'd0, 26'h40,      7'd8,  32'hC0FFEE00, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,  10,  8, 0};
    vecs[3]  = '{2'd1, 26'h40,      7'd8,  32'hC0FFEE00, 1'b1, 1'b1, 16'd2, 26'h48,    1'b0, 1'b0,  10,  8, 0};
    vecs[4]  = '{2'd2, 26'h300,     7'd4,  32'h00000001, 1'b0, 1'b0, 16'd0, 26'h0,     1'b1, 1'b0,  18, 16, 0};
    vecs[5]  = '{2'd0, 26'h100,     7'd0,  32'h0,        1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b1,   2,  0, 0};
    vecs[6]  = '{2'd3, 26'h100,     7'd4,  32'h0,        1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b1,   2,  0, 0};
    vecs[7]  = '{2'd1, 26'h100,     7'd65, 32'h0,        1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b1,   2,  0, 0};
    vecs[8]  = '{2'd0, 26'h13,      7'd1,  32'hDEADBEEF, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,   3,  1, 0};
    vecs[9]  = '{2'd1, 26'h100,     7'd4,  32'hA5A50000, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,   6,  4, 0};
    vecs[10] = '{2'd1, 26'h100,     7'd4,  32'hA5A50001, 1'b1, 1'b0, 16'd4, 26'h100,   1'b0, 1'b0,   6,  4, 0};
    vecs[11] = '{2'd0, 26'h3FFFFF8, 7'd4,  32'h5A5A5A5A, 1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0,   6,  4, 0};
    vecs[12] = '{2'd2, 26'h80,      7'd64, 32'h0,        1'b1, 1'b0, 16'd0, 26'h0,     1'b0, 1'b0, 131, 128, 1};

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset cmd_ready", cmd_ready, 0);
    chk("reset cyc", wb_cyc_o, 0);
    chk("reset stb", wb_stb_o, 0);
    chk("reset done", done, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset status", {timeout, illegal_cmd, first_err_addr}, 0);
    resetn = 1'b1;
    @(negedge sys_clk);
    chk("cmd_ready after release", cmd_ready, 1);

    for (int i = 0; i < 13; i++) run_cmd(i, vecs[i]);

    // Mid-burst reset during a wrapping read-check that is accumulating mismatches.
    ack_en = 1'b1; corrupt_en = 1'b0;
    issue(13, 2'd1, 26'h3FFFFF8, 7'd4, 32'h0);
    @(negedge sys_clk);
    chk("rst-seq beat0 addr", wb_addr_o, 26'h3FFFFF8);
    @(negedge sys_clk);
    chk("rst-seq beat1 addr", wb_addr_o, 26'h3FFFFFC);
    @(negedge sys_clk);
    chk("rst-seq beat2 addr", wb_addr_o, 26'h0);
    chk("rst-seq err before reset", err_cnt, 2);
    chk("rst-seq ferr before reset", first_err_addr, 26'h3FFFFF8);
    resetn = 1'b0;
    @(negedge sys_clk);
    chk("rst-seq cyc", wb_cyc_o, 0);
    chk("rst-seq stb", wb_stb_o, 0);
    chk("rst-seq done", done, 0);
    chk("rst-seq err_cnt", err_cnt, 0);
    chk("rst-seq ferr", first_err_addr, 0);
    chk("rst-seq cmd_ready in reset", cmd_ready, 0);
    resetn = 1'b1;
    @(negedge sys_clk);
    chk("rst-seq cmd_ready after release", cmd_ready, 1);
    chk("rst-seq bus idle after release", {wb_cyc_o, wb_stb_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
